// File: rtl/probescope_pkg.sv
// Shared sizing, FSM encoding and trigger-compare helper for the probe-scope capture block.
package probescope_pkg;

  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 10;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRETRIG   = 3'd1,
    WAIT_TRIG = 3'd2,
    POSTTRIG  = 3'd3,
    READOUT   = 3'd4
  } state_t;

  // Threshold crossing between two consecutive accepted samples.
  function automatic logic level_cross(input logic       rising,
                                       input logic [7:0] lvl,
                                       input logic [7:0] prev,
                                       input logic [7:0] cur);
    if (rising) begin
      level_cross = (prev < lvl) && (cur >= lvl);
    end else begin
      level_cross = (prev > lvl) && (cur <= lvl);
    end
  endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port 8-bit sample buffer: one write port, registered read with one cycle latency.
module capture_ram #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);
  import probescope_pkg::*;

  logic [7:0] mem [DEPTH];

  // Write port and registered read port; contents are never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/trigger_capture.sv
// Triggered ADC capture into a circular buffer with pre-trigger history and PMP byte readout.
module trigger_capture #(
  parameter int DEPTH  = probescope_pkg::DEPTH,
  parameter int ADDR_W = probescope_pkg::ADDR_W
) (
  input  logic              adc_dco,
  input  logic              rst,
  input  logic [7:0]        adc_data,
  input  logic              sample_en,
  input  logic              arm,
  input  logic              force_trig,
  input  logic [7:0]        trig_level,
  input  logic              trig_rising,
  input  logic [ADDR_W-1:0] pre_count,
  input  logic              pmp_dreq,
  output logic [7:0]        pmp_data,
  output logic              pmp_drdy,
  output logic              busy,
  output logic              triggered,
  output logic              done
);
  import probescope_pkg::*;

  localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] POST_BASE = ADDR_W'(DEPTH - 2);

  state_t            state_r, state_nxt;
  logic [ADDR_W-1:0] wr_ptr_r, rd_ptr_r, rd_idx_r, cnt_r, pre_r, trig_addr_r;
  logic [7:0]        lvl_r, prev_r, ram_q;
  logic              rising_r, prev_valid_r, force_pend_r;
  logic              dreq_meta_r, dreq_sync_r, dreq_last_r;
  logic              fetch1_r, fetch2_r;
  logic              wr_s, trig_hit_s, consume_s, enter_ro_s, dreq_edge_s;
  logic [ADDR_W-1:0] trig_src_s;

  assign dreq_edge_s = dreq_sync_r & ~dreq_last_r;

  // Next-state decode and per-cycle control strobes.
  always_comb begin
    state_nxt  = state_r;
    wr_s       = 1'b0;
    trig_hit_s = 1'b0;
    consume_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (arm) begin
          state_nxt = (pre_count == ZERO_ADDR) ? WAIT_TRIG : PRETRIG;
        end else begin
          state_nxt = IDLE;
        end
      end
      PRETRIG: begin
        if (sample_en) begin
          wr_s = 1'b1;
          if (cnt_r == pre_r - ONE_ADDR) begin
            state_nxt = WAIT_TRIG;
          end else begin
            state_nxt = PRETRIG;
          end
        end else begin
          state_nxt = PRETRIG;
        end
      end
      WAIT_TRIG: begin
        if (sample_en) begin
          wr_s = 1'b1;
          if (force_trig || force_pend_r ||
              (prev_valid_r && level_cross(rising_r, lvl_r, prev_r, adc_data))) begin
            trig_hit_s = 1'b1;
            // With a full-buffer pre-trigger window nothing remains to store afterwards.
            state_nxt  = (pre_r == LAST_IDX) ? READOUT : POSTTRIG;
          end else begin
            state_nxt = WAIT_TRIG;
          end
        end else begin
          state_nxt = WAIT_TRIG;
        end
      end
      POSTTRIG: begin
        if (sample_en) begin
          wr_s = 1'b1;
          if (cnt_r == POST_BASE - pre_r) begin
            state_nxt = READOUT;
          end else begin
            state_nxt = POSTTRIG;
          end
        end else begin
          state_nxt = POSTTRIG;
        end
      end
      READOUT: begin
        if (dreq_edge_s && pmp_drdy) begin
          consume_s = 1'b1;
          if (rd_idx_r == LAST_IDX) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = READOUT;
          end
        end else begin
          state_nxt = READOUT;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    enter_ro_s = (state_nxt == READOUT) && (state_r != READOUT);
    trig_src_s = trig_hit_s ? wr_ptr_r : trig_addr_r;
  end

  // FSM state register.
  always_ff @(posedge adc_dco) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Capture side: settings latch, write pointer, trigger history and status flags.
  always_ff @(posedge adc_dco) begin
    if (rst) begin
      wr_ptr_r     <= ZERO_ADDR;
      cnt_r        <= ZERO_ADDR;
      pre_r        <= ZERO_ADDR;
      trig_addr_r  <= ZERO_ADDR;
      lvl_r        <= 8'h00;
      prev_r       <= 8'h00;
      rising_r     <= 1'b0;
      prev_valid_r <= 1'b0;
      force_pend_r <= 1'b0;
      busy         <= 1'b0;
      triggered    <= 1'b0;
      done         <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      if (state_r == IDLE && arm) begin
        pre_r        <= pre_count;
        lvl_r        <= trig_level;
        rising_r     <= trig_rising;
        wr_ptr_r     <= ZERO_ADDR;
        cnt_r        <= ZERO_ADDR;
        prev_valid_r <= 1'b0;
        force_pend_r <= 1'b0;
        triggered    <= 1'b0;
        done         <= 1'b0;
      end else begin
        if (wr_s) begin
          wr_ptr_r     <= wr_ptr_r + ONE_ADDR;
          prev_r       <= adc_data;
          prev_valid_r <= 1'b1;
        end
        if (trig_hit_s) begin
          cnt_r       <= ZERO_ADDR;
          trig_addr_r <= wr_ptr_r;
          triggered   <= 1'b1;
        end else if (wr_s) begin
          cnt_r <= cnt_r + ONE_ADDR;
        end
        // A force seen between samples is held until the next accepted sample.
        force_pend_r <= (state_r == WAIT_TRIG) && !trig_hit_s && (force_trig || force_pend_r);
        if (consume_s && rd_idx_r == LAST_IDX) begin
          done <= 1'b1;
        end
      end
    end
  end

  // Readout side: dreq synchronizer, read pointer and the two-cycle RAM fetch pipeline.
  always_ff @(posedge adc_dco) begin
    if (rst) begin
      dreq_meta_r <= 1'b0;
      dreq_sync_r <= 1'b0;
      dreq_last_r <= 1'b0;
      rd_ptr_r    <= ZERO_ADDR;
      rd_idx_r    <= ZERO_ADDR;
      fetch1_r    <= 1'b0;
      fetch2_r    <= 1'b0;
      pmp_data    <= 8'h00;
      pmp_drdy    <= 1'b0;
    end else begin
      dreq_meta_r <= pmp_dreq;
      dreq_sync_r <= dreq_meta_r;
      dreq_last_r <= dreq_sync_r;
      fetch2_r    <= fetch1_r;
      if (enter_ro_s) begin
        rd_ptr_r <= trig_src_s - pre_r;
        rd_idx_r <= ZERO_ADDR;
        fetch1_r <= 1'b1;
        pmp_drdy <= 1'b0;
      end else if (consume_s) begin
        pmp_drdy <= 1'b0;
        if (rd_idx_r == LAST_IDX) begin
          fetch1_r <= 1'b0;
        end else begin
          rd_ptr_r <= rd_ptr_r + ONE_ADDR;
          rd_idx_r <= rd_idx_r + ONE_ADDR;
          fetch1_r <= 1'b1;
        end
      end else begin
        fetch1_r <= 1'b0;
        if (fetch2_r) begin
          pmp_data <= ram_q;
          pmp_drdy <= 1'b1;
        end
      end
    end
  end

  capture_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (adc_dco),
    .we    (wr_s),
    .waddr (wr_ptr_r),
    .wdata (adc_data),
    .raddr (rd_ptr_r),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_trigger_capture.sv
// Randomized and directed bench for trigger_capture against a sample-history reference model.
module tb_trigger_capture;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              adc_dco = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        adc_data = 8'h00;
  logic              sample_en = 1'b0;
  logic              arm = 1'b0;
  logic              force_trig = 1'b0;
  logic [7:0]        trig_level = 8'h00;
  logic              trig_rising = 1'b0;
  logic [ADDR_W-1:0] pre_count = '0;
  logic              pmp_dreq = 1'b0;
  logic [7:0]        pmp_data;
  logic              pmp_drdy, busy, triggered, done;

  int checks = 0;
  int passes = 0;
  logic [7:0] stim[$];
  logic [7:0] expq[$];

  trigger_capture #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .adc_dco(adc_dco), .rst(rst), .adc_data(adc_data), .sample_en(sample_en), .arm(arm),
    .force_trig(force_trig), .trig_level(trig_level), .trig_rising(trig_rising),
    .pre_count(pre_count), .pmp_dreq(pmp_dreq), .pmp_data(pmp_data), .pmp_drdy(pmp_drdy),
    .busy(busy), .triggered(triggered), .done(done)
  );

  always #5 adc_dco = ~adc_dco;

  task automatic tick();
    @(posedge adc_dco);
    #1;
  endtask

  // Reference: index of the trigger sample in the accepted-sample history, -1 if none.
  function automatic int find_trig(int pre, logic [7:0] lvl, logic rising, logic frc);
    for (int i = pre; i < stim.size(); i++) begin
      if (frc) return i;
      if (i > 0) begin
        if (rising && stim[i-1] < lvl && stim[i] >= lvl) return i;
        if (!rising && stim[i-1] > lvl && stim[i] <= lvl) return i;
      end
    end
    return -1;
  endfunction

  task automatic read_all(input int drop_at, input int stop_at);
    int waited = 0;
    while (pmp_drdy !== 1'b1 && waited < 3) begin
      tick();
      waited++;
    end
    checks++;
    if (pmp_drdy !== 1'b1) $display("FAIL first_drdy: got drdy=%b after %0d cycles, want 1 within 3", pmp_drdy, waited);
    else passes++;
    for (int k = 0; k < DEPTH; k++) begin
      checks++;
      if (pmp_data !== expq[k] || pmp_drdy !== 1'b1)
        $display("FAIL byte%0d: got data=%h drdy=%b, want data=%h drdy=1", k, pmp_data, pmp_drdy, expq[k]);
      else passes++;
      if (k == stop_at) return;
      pmp_dreq = 1'b1; sample_en = 1'($urandom); adc_data = 8'($urandom);
      tick();
      if (k == drop_at) pmp_dreq = 1'b0;
      tick();
      if (k == drop_at) pmp_dreq = 1'b1;
      checks++;
      if (pmp_drdy !== 1'b1) $display("FAIL drdy_t0_b%0d: got %b want 1", k, pmp_drdy);
      else passes++;
      tick();
      checks++;
      if (pmp_drdy !== 1'b0 || pmp_data !== expq[k])
        $display("FAIL drdy_t1_b%0d: got drdy=%b data=%h want drdy=0 data=%h", k, pmp_drdy, pmp_data, expq[k]);
      else passes++;
      if (k == DEPTH - 1) begin
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) $display("FAIL done_end: got done=%b busy=%b want 1/0", done, busy);
        else passes++;
      end
      tick();
      checks++;
      if (pmp_drdy !== 1'b0 || pmp_data !== expq[k])
        $display("FAIL drdy_t2_b%0d: got drdy=%b data=%h want drdy=0 data=%h", k, pmp_drdy, pmp_data, expq[k]);
      else passes++;
      tick();
      checks++;
      if (pmp_drdy !== (k < DEPTH - 1 ? 1'b1 : 1'b0))
        $display("FAIL drdy_t3_b%0d: got %b want %b", k, pmp_drdy, (k < DEPTH - 1));
      else passes++;
      pmp_dreq = 1'b0; sample_en = 1'b0;
      tick();
      tick();
    end
  endtask

  task automatic run_capture(input int pre, input logic [7:0] lvl, input logic rising,
                             input logic frc, input int drop_at, input int stop_at);
    int t, need;
    t = find_trig(pre, lvl, rising, frc);
    need = t + DEPTH - pre;
    pre_count = ADDR_W'(pre); trig_level = lvl; trig_rising = rising; force_trig = frc;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    trig_level = 8'($urandom); trig_rising = 1'($urandom); pre_count = ADDR_W'($urandom);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || triggered !== 1'b0)
      $display("FAIL arm_state: got busy=%b done=%b trig=%b want 1/0/0", busy, done, triggered);
    else passes++;
    for (int i = 0; i < need; i++) begin
      adc_data = stim[i]; sample_en = 1'b1;
      tick();
      sample_en = 1'b0; adc_data = 8'($urandom);
      if (i == t || i == t - 1) begin
        checks++;
        if (triggered !== (i == t)) $display("FAIL triggered_s%0d: got %b want %b", i, triggered, (i == t));
        else passes++;
      end
      if (i < need - 1) repeat ($urandom_range(0, 2)) tick();
    end
    force_trig = 1'b0;
    expq = {};
    for (int k = 0; k < DEPTH; k++) expq.push_back(stim[t - pre + k]);
    read_all(drop_at, stop_at);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({pmp_data, pmp_drdy, busy, triggered, done} !== 12'h000)
      $display("FAIL reset: got data=%h drdy=%b busy=%b trig=%b done=%b want all 0", pmp_data, pmp_drdy, busy, triggered, done);
    else passes++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_ramp_rising();
    stim = {};
    for (int i = 0; i < 32; i++) stim.push_back(8'(8'h70 + i));
    run_capture(4, 8'h80, 1'b1, 1'b0, 5, DEPTH);
  endtask

  task automatic test_falling();
    stim = {8'h50, 8'h45, 8'h40};
    for (int i = 0; i < 20; i++) stim.push_back(8'(8'h30 - i));
    run_capture(1, 8'h40, 1'b0, 1'b0, DEPTH, DEPTH);
    stim = {};
    for (int i = 0; i < 40; i++) stim.push_back(8'h40);
    pre_count = ADDR_W'(2); trig_level = 8'h40; trig_rising = 1'b0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int i = 0; i < 40; i++) begin
      adc_data = stim[i]; sample_en = 1'b1;
      tick();
    end
    sample_en = 1'b0;
    checks++;
    if (triggered !== 1'b0 || busy !== 1'b1 || done !== 1'b0)
      $display("FAIL flat_no_trig: got trig=%b busy=%b done=%b want 0/1/0", triggered, busy, done);
    else passes++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({pmp_data, pmp_drdy, busy, triggered, done} !== 12'h000)
      $display("FAIL flat_reset: got data=%h drdy=%b busy=%b trig=%b done=%b want all 0", pmp_data, pmp_drdy, busy, triggered, done);
    else passes++;
  endtask

  task automatic test_first_sample();
    stim = {8'hFF, 8'h05, 8'h20};
    for (int i = 0; i < 20; i++) stim.push_back(8'($urandom));
    run_capture(0, 8'h10, 1'b1, 1'b0, DEPTH, DEPTH);
  endtask

  task automatic test_force_flat();
    stim = {};
    for (int i = 0; i < 20; i++) stim.push_back(8'h22);
    run_capture(0, 8'h80, 1'b1, 1'b1, DEPTH, DEPTH);
  endtask

  task automatic test_reset_mid();
    stim = {};
    for (int i = 0; i < 32; i++) stim.push_back(8'(8'h70 + i));
    pre_count = ADDR_W'(4); trig_level = 8'h80; trig_rising = 1'b1;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int i = 0; i < 20; i++) begin
      adc_data = stim[i]; sample_en = 1'b1;
      tick();
    end
    sample_en = 1'b0;
    checks++;
    if (triggered !== 1'b1 || busy !== 1'b1) $display("FAIL posttrig_state: got trig=%b busy=%b want 1/1", triggered, busy);
    else passes++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({pmp_data, pmp_drdy, busy, triggered, done} !== 12'h000)
      $display("FAIL posttrig_reset: got data=%h drdy=%b busy=%b trig=%b done=%b want all 0", pmp_data, pmp_drdy, busy, triggered, done);
    else passes++;
    stim = {};
    for (int i = 0; i < 40; i++) stim.push_back(8'($urandom));
    run_capture(3, 8'h00, 1'b1, 1'b1, DEPTH, 7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({pmp_data, pmp_drdy, busy, triggered, done} !== 12'h000)
      $display("FAIL readout_reset: got data=%h drdy=%b busy=%b trig=%b done=%b want all 0", pmp_data, pmp_drdy, busy, triggered, done);
    else passes++;
    tick();
    test_ramp_rising();
  endtask

  task automatic test_random();
    for (int it = 0; it < 5; it++) begin
      int pre, v, t;
      logic [7:0] lvl;
      logic rising, frc;
      pre = (it == 0) ? DEPTH - 1 : int'($urandom_range(0, DEPTH - 1));
      lvl = 8'($urandom);
      rising = 1'($urandom);
      stim = {};
      v = int'($urandom_range(0, 255));
      for (int i = 0; i < 100; i++) begin
        v = v + int'($urandom_range(0, 80)) - 40;
        if (v < 0) v = 0;
        if (v > 255) v = 255;
        stim.push_back(8'(v));
      end
      t = find_trig(pre, lvl, rising, 1'b0);
      frc = (t < 0 || t + DEPTH - pre > 100) ? 1'b1 : 1'b0;
      run_capture(pre, lvl, rising, frc, int'($urandom_range(0, DEPTH - 1)), DEPTH);
    end
  endtask

  initial begin
    test_reset();
    test_ramp_rising();
    test_falling();
    test_first_sample();
    test_force_flat();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/trigger_capture.md
TRIGGER_CAPTURE -- requirements
Module: trigger_capture

Interface
REQ-001 Parameter DEPTH, default 1024, capture buffer length in samples; SHALL be a power of two.
REQ-002 Parameter ADDR_W, default 10, buffer address width; SHALL equal log2(DEPTH).
REQ-003 adc_dco  in  1  sole clock; all logic SHALL be on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 adc_data  in  8  decimated ADC sample from the acquisition stage.
REQ-006 sample_en  in  1  one-cycle strobe marking adc_data valid.
REQ-007 arm  in  1  start-capture request, level-sampled.
REQ-008 force_trig  in  1  unconditional trigger while waiting.
REQ-009 trig_level  in  8  trigger threshold, unsigned.
REQ-010 trig_rising  in  1  1 = rising-edge trigger, 0 = falling-edge trigger.
REQ-011 pre_count  in  ADDR_W  pre-trigger sample count.
REQ-012 pmp_dreq  in  1  asynchronous byte request from the host PMP.
REQ-013 pmp_data  out  8  readout byte to the PMP.
REQ-014 pmp_drdy  out  1  pmp_data valid.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 triggered  out  1  trigger has occurred in the current capture.
REQ-017 done  out  1  last capture fully read out; cleared on the next accepted arm.

Function
REQ-018 FSM states SHALL be IDLE, PRETRIG, WAIT_TRIG, POSTTRIG, READOUT.
REQ-019 IDLE: arm=1 SHALL latch pre_count and trig settings, clear done, reset the write pointer to 0, and enter PRETRIG; arm in any other state SHALL be ignored.
REQ-020 Each sample_en in PRETRIG, WAIT_TRIG or POSTTRIG SHALL write adc_data at the write pointer, then increment the pointer modulo DEPTH (wrap-around).
REQ-021 PRETRIG SHALL enter WAIT_TRIG after pre_count samples; pre_count=0 SHALL enter WAIT_TRIG directly.
REQ-022 Rising trigger SHALL be prev<trig_level and cur>=trig_level; falling trigger SHALL be prev>trig_level and cur<=trig_level; prev is the previous accepted sample.
REQ-023 The first sample after arm SHALL NOT trigger, because it has no valid prev.
REQ-024 force_trig=1 in WAIT_TRIG SHALL trigger on the next sample_en regardless of level.
REQ-025 The trigger sample SHALL be written; its address SHALL be saved as trig_addr; triggered SHALL be set; state SHALL enter POSTTRIG.
REQ-026 POSTTRIG SHALL store DEPTH-1-pre_count further samples, then enter READOUT.
REQ-027 Total stored samples after the trigger, including the trigger sample, SHALL be DEPTH-pre_count.
REQ-028 Readout start address SHALL be (trig_addr-pre_count) mod DEPTH, so the trigger sample is readout byte index pre_count.
REQ-029 Exactly DEPTH bytes SHALL be read out, in address order modulo DEPTH.
REQ-030 pmp_dreq SHALL pass through a 2-flop synchronizer, then a rising-edge detector.
REQ-031 On READOUT entry, byte 0 SHALL be on pmp_data with pmp_drdy=1 within 3 cycles.
REQ-032 A detected dreq edge while pmp_drdy=1 at cycle t SHALL drive pmp_drdy=0 at t+1, then the next byte on pmp_data and pmp_drdy=1 at t+3.
REQ-033 A dreq edge while pmp_drdy=0 SHALL be ignored.
REQ-034 The dreq edge that consumes byte DEPTH-1 SHALL enter IDLE, set done=1, and keep pmp_drdy=0.
REQ-035 Simultaneous sample_en and dreq edge SHALL NOT interact; samples are not accepted in READOUT.
REQ-036 pmp_data SHALL hold its value while pmp_drdy=0.

Reset
REQ-037 rst SHALL force IDLE from any state, including mid-capture and mid-readout.
REQ-038 rst SHALL clear the write pointer, read pointer, prev-valid, synchronizer flops, pmp_data=0x00, pmp_drdy=0, busy=0, triggered=0 and done=0.
REQ-039 Buffer contents SHALL NOT be cleared by reset.

Structure
REQ-040 Package probescope_pkg SHALL hold DEPTH, ADDR_W and the FSM state encoding.
REQ-041 Sub-module capture_ram SHALL be a simple dual-port RAM, 8xDEPTH, with one write port and a synchronous read of 1-cycle latency, inferable to block RAM.

Verification
REQ-042 DEPTH=16, pre_count=4, rising, level=0x80, ramp 0x70..0x8F -> trigger at 0x80; readout is 0x7C..0x8B, with byte 4 = 0x80.
REQ-043 Falling, level=0x40, samples 0x50,0x45,0x40 -> trigger on 0x40; a constant 0x40 input never triggers.
REQ-044 First sample after arm = 0xFF with level=0x10, rising -> no trigger, because there is no valid prev.
REQ-045 pre_count=0, force_trig on a flat 0x22 input -> readout byte 0 = the trigger sample; wrap start address = trig_addr.
REQ-046 Toggle pmp_dreq with 5-cycle spacing -> each drdy low/high sequence matches t+1/t+3, 16 bytes total, then done=1 and busy=0; a dreq edge during drdy=0 is dropped.
REQ-047 Assert rst during POSTTRIG and during byte 7 of readout -> IDLE next cycle with all outputs at reset values; a following arm runs a clean capture.
